// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte-stream
// requesters; a grant is held for a whole packet and bytes are spaced by GAP_CYCLES.
module uart_tx_arbiter #(
    parameter int NREQ       = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_en,
    output logic [7:0]        tx_din,
    input  logic              tx_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);
    localparam int            OW       = (NREQ > 2) ? 2 : 1;
    localparam logic [OW-1:0] LAST_IDX = OW'(NREQ - 1);
    localparam logic [15:0]   GAP_LOAD = 16'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_BLANK,
        S_WAIT,
        S_GAP
    } state_t;

    state_t        state;
    logic [OW-1:0] owner;
    logic [OW-1:0] ptr;
    logic [OW-1:0] pick;
    logic          last_q;
    logic          blank_cnt;
    logic [15:0]   gap_cnt;
    logic          load_xfer;
    logic          byte_done;

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [NREQ-1:0] one_hot(input logic [OW-1:0] idx);
        logic [NREQ-1:0] g;
        g      = '0;
        g[idx] = 1'b1;
        return g;
    endfunction

    // First valid requester found walking upward from ptr, wrapping at NREQ.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [OW-1:0]   p);
        logic [OW-1:0] idx;
        logic [OW-1:0] sel;
        logic          found;
        idx   = p;
        sel   = p;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && v[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return sel;
    endfunction

    always_comb begin
        pick = rr_pick(req_valid, ptr);
    end

    always_comb begin
        req_ready = '0;
        if (state == S_LOAD) begin
            req_ready[owner] = req_valid[owner];
        end
    end

    assign load_xfer = (state == S_LOAD) && req_valid[owner];
    assign byte_done = ((state == S_WAIT) && tx_ready && (GAP_CYCLES == 0)) ||
                       ((state == S_GAP) && (gap_cnt == 16'd1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            owner     <= '0;
            ptr       <= '0;
            last_q    <= 1'b0;
            blank_cnt <= 1'b0;
            gap_cnt   <= '0;
            tx_en     <= 1'b0;
            tx_din    <= 8'h00;
            grant     <= '0;
            busy      <= 1'b0;
        end else begin
            tx_en <= 1'b0;
            if (byte_done) begin
                gap_cnt <= '0;
                if (last_q) begin
                    state <= S_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    ptr   <= next_idx(owner);
                end else begin
                    state <= S_LOAD;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if ((|req_valid) && tx_ready) begin
                            owner <= pick;
                            grant <= one_hot(pick);
                            busy  <= 1'b1;
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (load_xfer) begin
                            tx_din <= req_data[{owner, 3'b000} +: 8];
                            last_q <= req_last[owner];
                            tx_en  <= 1'b1;
                            state  <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        blank_cnt <= 1'b0;
                        state     <= S_BLANK;
                    end
                    // txready from the UART lags txen, so it is not trusted yet.
                    S_BLANK: begin
                        blank_cnt <= 1'b1;
                        if (blank_cnt) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (tx_ready) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: packet-level round-robin reference model,
// simple UART busy-time model, and a second instance exercising the inter-byte gap.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NR        = 3;
    localparam int BAUD_BYTE = 10 * (100_000_000 / 115200);

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    logic [NR-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*NR-1:0] req_data;
    logic            tx_en, tx_ready, busy;
    logic [7:0]      tx_din;

    logic [1:0]      g_valid, g_last, g_ready, g_grant;
    logic [15:0]     g_data;
    logic            g_tx_en, g_tx_ready, g_busy;
    logic [7:0]      g_din;

    uart_tx_arbiter #(.NREQ(NR), .GAP_CYCLES(0)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .tx_en(tx_en), .tx_din(tx_din),
        .tx_ready(tx_ready), .grant(grant), .busy(busy)
    );

    uart_tx_arbiter #(.NREQ(2), .GAP_CYCLES(10)) dut_gap (
        .clock(clock), .reset(reset),
        .req_valid(g_valid), .req_last(g_last), .req_data(g_data),
        .req_ready(g_ready), .tx_en(g_tx_en), .tx_din(g_din),
        .tx_ready(g_tx_ready), .grant(g_grant), .busy(g_busy)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [8:0] rq [NR][$];
    int         hold [NR];
    logic       rand_hold = 1'b0;
    logic       rand_uart = 1'b0;
    int         byte_cyc  = 20;
    int         uart_cnt  = 0;
    logic       prev_rdy  = 1'b1;
    logic [NR-1:0] prev_grant = '0;
    int         rise_cyc  = -1;
    int         rel_cyc   = -1;
    logic [7:0] rx_q[$];
    int         pulse_cyc[$];
    logic [7:0] exp_q[$];
    int         mptr = 0;

    function automatic int pending();
        int n = 0;
        for (int r = 0; r < NR; r++) n += rq[r].size();
        return n;
    endfunction

    // One clock: UART model, requester drivers, then handshake bookkeeping.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (tx_en) begin
            rx_q.push_back(tx_din);
            pulse_cyc.push_back(cyc);
            uart_cnt = rand_uart ? int'($urandom_range(0, 8)) : byte_cyc;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
        end
        tx_ready = (uart_cnt == 0);
        if (tx_ready && !prev_rdy) rise_cyc = cyc;
        prev_rdy = tx_ready;
        for (int r = 0; r < NR; r++) begin
            if (hold[r] > 0) begin
                hold[r]--;
                req_valid[r] = 1'b0;
                req_last[r]  = 1'($urandom_range(0, 1));
            end else if (rq[r].size() > 0) begin
                req_valid[r]         = 1'b1;
                req_last[r]          = rq[r][0][8];
                req_data[8*r +: 8]   = rq[r][0][7:0];
            end else begin
                req_valid[r]         = 1'b0;
                req_last[r]          = 1'($urandom_range(0, 1));
                req_data[8*r +: 8]   = 8'($urandom);
            end
        end
        #1;
        for (int r = 0; r < NR; r++) begin
            if (req_valid[r] && req_ready[r]) begin
                if (!rq[r][0][8] && rand_hold) hold[r] = int'($urandom_range(0, 5));
                void'(rq[r].pop_front());
            end
        end
        if (prev_grant != '0 && grant == '0) rel_cyc = cyc;
        prev_grant = grant;
    endtask

    // Packet-level reference: repeatedly serve the first requester at or after
    // the pointer that still has packets, emitting its whole packet.
    task automatic build_expected();
        logic [8:0] cp [NR][$];
        logic [8:0] w;
        int sel;
        exp_q.delete();
        for (int r = 0; r < NR; r++) cp[r] = rq[r];
        while (1) begin
            sel = -1;
            for (int i = 0; i < NR; i++) begin
                if (sel < 0 && cp[(mptr + i) % NR].size() > 0) sel = (mptr + i) % NR;
            end
            if (sel < 0) break;
            do begin
                w = cp[sel].pop_front();
                exp_q.push_back(w[7:0]);
            end while (!w[8]);
            mptr = (sel + 1) % NR;
        end
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while ((pending() > 0 || busy || uart_cnt > 0) && n < limit) begin
            step();
            n++;
        end
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL %s timeout: busy=%0b pending=%0d, required idle within %0d cycles",
                     name, busy, pending(), limit);
        end
    endtask

    task automatic compare_rx(input string name);
        total++;
        if (rx_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s byte count: got %0d required %0d", name, rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s byte %0d: got %h required %h", name, i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic clear_bench();
        for (int r = 0; r < NR; r++) begin
            rq[r].delete();
            hold[r] = 0;
        end
        rx_q.delete();
        pulse_cyc.delete();
        uart_cnt   = 0;
        tx_ready   = 1'b1;
        prev_rdy   = 1'b1;
        prev_grant = '0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = '1;
        repeat (3) @(posedge clock);
        #1;
        total += 5;
        if (tx_en !== 1'b0)     begin bad++; $display("FAIL reset tx_en: got %b required 0", tx_en); end
        if (tx_din !== 8'h00)   begin bad++; $display("FAIL reset tx_din: got %h required 00", tx_din); end
        if (grant !== '0)       begin bad++; $display("FAIL reset grant: got %b required 0", grant); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL reset busy: got %b required 0", busy); end
        if (req_ready !== '0)   begin bad++; $display("FAIL reset req_ready: got %b required 0", req_ready); end
        @(negedge clock);
        req_valid = '0;
        reset     = 1'b1;
    endtask

    task automatic test_single_byte();
        int start;
        byte_cyc = BAUD_BYTE;
        clear_bench();
        rq[0].push_back({1'b1, 8'h41});
        build_expected();
        start = cyc + 1;
        drain("single", 10000);
        compare_rx("single");
        total += 2;
        if (pulse_cyc.size() != 1 || pulse_cyc[0] != start + 2) begin
            bad++;
            $display("FAIL single pulse: got %0d pulses first at +%0d, required 1 at +2",
                     pulse_cyc.size(), (pulse_cyc.size() > 0) ? pulse_cyc[0] - start : -1);
        end
        if (rel_cyc != rise_cyc + 1) begin
            bad++;
            $display("FAIL single release: grant cleared at %0d, required %0d", rel_cyc, rise_cyc + 1);
        end
        byte_cyc = 20;
    endtask

    task automatic test_reset_mid_send();
        int n = 0;
        clear_bench();
        rq[1].push_back({1'b1, 8'h5A});
        while (!tx_en && n < 20) begin step(); n++; end
        total++;
        if (!tx_en) begin bad++; $display("FAIL midsend reach: tx_en got %b required 1", tx_en); end
        req_valid = '1;
        reset = 1'b0;
        #1;
        total += 5;
        if (tx_en !== 1'b0)   begin bad++; $display("FAIL midsend tx_en: got %b required 0", tx_en); end
        if (tx_din !== 8'h00) begin bad++; $display("FAIL midsend tx_din: got %h required 00", tx_din); end
        if (grant !== '0)     begin bad++; $display("FAIL midsend grant: got %b required 0", grant); end
        if (busy !== 1'b0)    begin bad++; $display("FAIL midsend busy: got %b required 0", busy); end
        if (req_ready !== '0) begin bad++; $display("FAIL midsend req_ready: got %b required 0", req_ready); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear_bench();
        req_valid = '0;
        reset = 1'b1;
        mptr  = 0;
        step();
        total++;
        if (busy !== 1'b0 || grant !== '0) begin
            bad++;
            $display("FAIL midsend idle: busy=%b grant=%b required 0/0", busy, grant);
        end
        rq[0].push_back({1'b1, 8'h30});
        rq[1].push_back({1'b1, 8'h31});
        build_expected();
        drain("ptr_after_reset", 500);
        compare_rx("ptr_after_reset");
    endtask

    task automatic test_two_packets();
        logic seen = 1'b0;
        int   n    = 0;
        clear_bench();
        rq[0].push_back({1'b0, "a"}); rq[0].push_back({1'b1, "b"});
        rq[1].push_back({1'b0, "C"}); rq[1].push_back({1'b1, "D"});
        build_expected();
        while (rq[0].size() > 0 && n < 300) begin
            step();
            n++;
            if (req_ready[1]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL two_pkt ready1: got %b required 0", seen); end
        drain("two_pkt", 500);
        compare_rx("two_pkt");
    endtask

    task automatic test_back_to_back();
        clear_bench();
        rq[0].push_back({1'b0, 8'h10}); rq[0].push_back({1'b1, 8'h11});
        rq[0].push_back({1'b1, 8'h12});
        rq[1].push_back({1'b0, 8'h20}); rq[1].push_back({1'b1, 8'h21});
        build_expected();
        drain("back_to_back", 800);
        compare_rx("back_to_back");
    endtask

    task automatic test_owner_drop();
        int   n = 0;
        int   p;
        logic grant_bad = 1'b0;
        logic ready_bad = 1'b0;
        clear_bench();
        rq[0].push_back({1'b0, "x"}); rq[0].push_back({1'b0, "y"}); rq[0].push_back({1'b1, "z"});
        while (rq[0].size() > 2 && n < 50) begin step(); n++; end
        hold[0] = 50;
        rq[1].push_back({1'b1, "Q"});
        step();
        p = pulse_cyc.size();
        repeat (45) begin
            step();
            if (grant !== 3'b001) grant_bad = 1'b1;
            if (req_ready[1] !== 1'b0) ready_bad = 1'b1;
        end
        total += 3;
        if (grant_bad) begin bad++; $display("FAIL drop grant: got %b required 001", grant); end
        if (ready_bad) begin bad++; $display("FAIL drop ready1: got 1 required 0"); end
        if (pulse_cyc.size() != p) begin
            bad++;
            $display("FAIL drop pulses: got %0d required %0d", pulse_cyc.size(), p);
        end
        exp_q.delete();
        exp_q.push_back("x"); exp_q.push_back("y"); exp_q.push_back("z"); exp_q.push_back("Q");
        mptr = 2;
        drain("drop", 500);
        compare_rx("drop");
    endtask

    task automatic test_random();
        rand_hold = 1'b1;
        rand_uart = 1'b1;
        for (int it = 0; it < 6; it++) begin
            clear_bench();
            for (int r = 0; r < NR; r++) begin
                int npkt = int'($urandom_range(0, 3));
                for (int k = 0; k < npkt; k++) begin
                    int nb = int'($urandom_range(1, 4));
                    for (int b = 0; b < nb; b++) rq[r].push_back({(b == nb - 1), 8'($urandom)});
                end
            end
            build_expected();
            drain("random", 5000);
            compare_rx("random");
        end
        rand_hold = 1'b0;
        rand_uart = 1'b0;
    endtask

    task automatic test_gap();
        logic [7:0] gb [3];
        logic [7:0] gd[$];
        int         gp[$];
        int         idx = 0;
        int         gc  = 0;
        gb[0] = 8'h31; gb[1] = 8'h32; gb[2] = 8'h33;
        for (int c = 0; c < 200 && !(idx == 3 && !g_busy); c++) begin
            @(negedge clock);
            gc++;
            if (g_tx_en) begin
                gp.push_back(gc);
                gd.push_back(g_din);
            end
            if (idx < 3) begin
                g_valid     = 2'b01;
                g_data[7:0] = gb[idx];
                g_last[0]   = (idx == 2);
            end else begin
                g_valid = 2'b00;
            end
            #1;
            if (g_valid[0] && g_ready[0]) idx++;
        end
        total++;
        if (gp.size() != 3) begin
            bad++;
            $display("FAIL gap pulses: got %0d required 3", gp.size());
        end
        for (int i = 1; i < gp.size(); i++) begin
            total++;
            if (gp[i] - gp[i-1] != 15) begin
                bad++;
                $display("FAIL gap spacing %0d: got %0d required 15", i, gp[i] - gp[i-1]);
            end
        end
        for (int i = 0; i < gd.size() && i < 3; i++) begin
            total++;
            if (gd[i] !== gb[i]) begin
                bad++;
                $display("FAIL gap byte %0d: got %h required %h", i, gd[i], gb[i]);
            end
        end
    endtask

    initial begin
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        tx_ready   = 1'b1;
        g_valid    = '0;
        g_last     = '0;
        g_data     = '0;
        g_tx_ready = 1'b1;
        for (int r = 0; r < NR; r++) hold[r] = 0;
        test_reset();
        test_single_byte();
        test_reset_mid_send();
        test_two_packets();
        test_back_to_back();
        test_owner_drop();
        test_random();
        test_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
